// File: rtl/nn_frame_sequencer.sv
// Frame sequencer between the UART byte receiver and the neural-network MAC datapath.
// Builds the input frame, starts inference, drives the scope trigger and returns the 24-bit result.
module nn_frame_sequencer #(
    parameter int N_BYTES     = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_recv_i,
    input  logic [7:0]           byte_in_i,
    input  logic [3:0]           sw_i,
    input  logic                 nn_done_i,
    input  logic [23:0]          nn_result_i,
    input  logic                 tx_ready_i,
    output logic                 nn_start_o,
    output logic [8*N_BYTES-1:0] nn_in_o,
    output logic                 trig_out_o,
    output logic [4:0]           byte_cnt_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_byte_o,
    output logic                 busy_o,
    output logic                 timeout_err_o
);

    // Counter is at least 5 bits so the 4-bit trigger delay always fits beside it.
    localparam int CW_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW     = (CW_RAW > 5) ? CW_RAW : 5;

    localparam logic [CW-1:0] RUN_LAST  = CW'(TIMEOUT_CYC - 2);
    localparam logic [4:0]    LAST_BYTE = 5'(N_BYTES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        RUN     = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t        state_q;
    logic [4:0]    byte_cnt_q;
    logic [3:0]    dly_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   res_q;
    logic [1:0]    tx_idx_q;
    logic          nn_start_q;
    logic          trig_q;
    logic          tx_valid_q;
    logic [7:0]    tx_byte_q;
    logic          timeout_err_q;
    logic [7:0]    lane_q [N_BYTES];

    logic          accept_d;
    logic [CW-1:0] cnt_d;
    logic          trig_hit_d;

    assign accept_d   = (state_q == COLLECT) && byte_recv_i;
    assign cnt_d      = cnt_q + 1'b1;
    // The trigger must be high in the RUN cycle whose count equals the latched delay.
    assign trig_hit_d = (cnt_d == {{(CW-4){1'b0}}, dly_q});

    genvar gi;
    generate
        for (gi = 0; gi < N_BYTES; gi++) begin : g_lane
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_q[gi] <= 8'h00;
                end else if (accept_d && (byte_cnt_q == 5'(gi))) begin
                    lane_q[gi] <= byte_in_i;
                end
            end
            assign nn_in_o[8*gi +: 8] = lane_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= COLLECT;
            byte_cnt_q    <= 5'd0;
            dly_q         <= 4'd0;
            cnt_q         <= '0;
            res_q         <= 16'h0000;
            tx_idx_q      <= 2'd0;
            nn_start_q    <= 1'b0;
            trig_q        <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_byte_q     <= 8'h00;
            timeout_err_q <= 1'b0;
        end else begin
            nn_start_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (byte_recv_i) begin
                        if (byte_cnt_q == 5'd0) begin
                            timeout_err_q <= 1'b0;
                        end
                        byte_cnt_q <= byte_cnt_q + 5'd1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            nn_start_q <= 1'b1;
                            state_q    <= START;
                        end
                    end
                end
                START: begin
                    dly_q   <= sw_i;
                    cnt_q   <= '0;
                    trig_q  <= (sw_i == 4'd0);
                    state_q <= RUN;
                end
                RUN: begin
                    // A result arriving on the last allowed cycle still beats the abort.
                    if (nn_done_i) begin
                        res_q      <= nn_result_i[15:0];
                        tx_byte_q  <= nn_result_i[23:16];
                        tx_idx_q   <= 2'd0;
                        tx_valid_q <= 1'b1;
                        trig_q     <= 1'b0;
                        state_q    <= SEND;
                    end else if (cnt_q == RUN_LAST) begin
                        timeout_err_q <= 1'b1;
                        trig_q        <= 1'b0;
                        byte_cnt_q    <= 5'd0;
                        state_q       <= COLLECT;
                    end else begin
                        cnt_q <= cnt_d;
                        if (trig_hit_d) begin
                            trig_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (tx_ready_i) begin
                        case (tx_idx_q)
                            2'd0: begin
                                tx_byte_q <= res_q[15:8];
                                tx_idx_q  <= 2'd1;
                            end
                            2'd1: begin
                                tx_byte_q <= res_q[7:0];
                                tx_idx_q  <= 2'd2;
                            end
                            default: begin
                                tx_valid_q <= 1'b0;
                                tx_idx_q   <= 2'd0;
                                byte_cnt_q <= 5'd0;
                                state_q    <= COLLECT;
                            end
                        endcase
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign nn_start_o    = nn_start_q;
    assign trig_out_o    = trig_q;
    assign byte_cnt_o    = byte_cnt_q;
    assign tx_valid_o    = tx_valid_q;
    assign tx_byte_o     = tx_byte_q;
    assign busy_o        = (state_q != COLLECT);
    assign timeout_err_o = timeout_err_q;

endmodule
